keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad and produces one debounced 4-bit key code per press, with a single-cycle valid strobe. Codes 0–9 are digit keys and codes 10–15 are command keys. The code stream feeds the key-splitting logic that routes digits and commands to their separate consumers. The block is the producer end of that 4-bit key interface and sits between the board keypad pins and the key-handling datapath.

## Interface
- SCAN_DIV, 4: clock cycles each column is driven before its rows are sampled; legal range is 3 or more.
- DEBOUNCE, 3: consecutive identical samples needed to accept a press, and consecutive all-high samples needed to accept a release; legal range is 1 or more.
- REPEAT, 5: samples between repeated strobes while a key is held; used only with KEYPAD_AUTOREPEAT_EN.
- clk  in  1  Single system clock.
- rst  in  1  Reset, synchronous, active-high.
- row  in  4  Keypad row lines. Active-low, externally pulled up, asynchronous to clk.
- col  out  4  Column drive. Active-low, exactly one bit low at any time.
- key  out  4  Accepted key code, = row_index*4 + col_index.
- key_vld  out  1  One-cycle strobe; key is valid in that cycle.
- key_held  out  1  High while the accepted key remains pressed.

## Operation
- row passes through a 2-flop synchronizer. Only the synchronized value (rs) is used internally.
- A dwell counter runs 0..SCAN_DIV-1. A sample is taken in the cycle where the counter equals SCAN_DIV-1.
- State machine:
  - SCAN:
    - Advance col one step per dwell: 1110, 1101, 1011, 0111, then wrap back to 1110.
    - At a sample with exactly one rs bit low: latch the code, set the match count to 1, hold the current column, go to DEB.
    - At a sample with zero low bits: advance to the next column.
    - At a sample with two or more low bits (ghosting): ignore it and advance to the next column.
  - DEB:
    - Column held. At each sample, if rs equals the latched pattern, increment the match count.
    - When the count reaches DEBOUNCE, pulse key_vld and go to HELD.
    - Any differing sample: return to SCAN and advance to the next column.
  - HELD:
    - Column held, key_held=1.
    - Each all-high sample increments a release count. Any sample that is not all-high clears it, including a different row pattern.
    - When the release count reaches DEBOUNCE: set key_held=0 and go to SCAN at the next column.
- With DEBOUNCE=1, SCAN goes directly to a key_vld pulse and HELD.
- key is updated only in the cycle key_vld rises. It holds its value until the next accepted press.

## Timing
- Reset values: col=1110, key=0, key_vld=0, key_held=0. State is SCAN; all counters are 0.
- rst asserted mid-operation wins over every other event in that cycle. No strobe is emitted in the reset cycle or in the cycle after it.
- key_vld goes high in the cycle after the DEBOUNCE-th matching sample and lasts exactly 1 cycle.
- Press-to-strobe latency from a stable rs transition:
  - At most (4 + DEBOUNCE)*SCAN_DIV + 1 cycles.
  - Add 2 cycles for synchronizer delay.
- A column change takes effect on the cycle after a sample. This gives SCAN_DIV-1 cycles of settling before the next sample.
- Strobe spacing without autorepeat: at least 2*DEBOUNCE*SCAN_DIV cycles.

## Configuration
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter increments on every sample whose pattern equals the latched pattern.
  - When the counter reaches REPEAT, key_vld pulses again with the same key and the counter resets to 0.
  - The counter is also reset on entering HELD and on any sample that does not match.
- Undefined: exactly one key_vld per press; no repeat logic is synthesized.

## Structure
- Shared package keypad_pkg holds:
  - The state enum (SCAN, DEB, HELD).
  - KEY_W=4.
  - KEY_DIGIT_MAX=9, the boundary between digit and command codes.
  - COL_RESET=4'b1110.
- Sub-module keypad_row_sync: 4-bit, 2-flop synchronizer with synchronous reset to 4'b1111.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3 unless noted.
- Reset: assert rst for 2 cycles with row=1111 → col=1110, key=0, key_vld=0, key_held=0. col reaches 1101 four cycles after rst is released.
- Single press: row1/col2 (code 6) held for 200 cycles → exactly one key_vld with key=6. key_held is high until 3 all-high samples after release.
- Bounce: code 6 held for 2 samples (8 cycles) then released → no key_vld, and the scan resumes cycling columns.
- Ghosting: rows 0 and 2 low while col0 is driven → no key_vld, and col keeps advancing.
- Sequence: code 15 press and release, then code 0 press → two key_vld pulses, key=15 then key=0, with key_held low between them.
- Reset mid-DEB: assert rst after 2 matching samples of code 9 → no strobe, outputs return to reset values, and the press is re-detected from scratch afterwards.
- Autorepeat, with KEYPAD_AUTOREPEAT_EN and REPEAT=5: code 12 held → first strobe, then repeat strobes every 20 cycles, all with key=12.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, constants and small decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB,
    HELD
  } state_t;

  localparam int         KEY_W         = 4;
  localparam int         KEY_DIGIT_MAX = 9;
  localparam logic [3:0] COL_RESET     = 4'b1110;

  // Number of active-low lines in a 4-bit pattern.
  function automatic logic [2:0] low_count(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Position of the lowest active-low line; meaningful only when exactly one is low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Digit keys are 0..9, everything above is a command key.
  function automatic logic is_digit(input logic [KEY_W-1:0] k);
    return k <= KEY_W'(KEY_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Producer-side key code interface: one code per accepted press with a 1-cycle strobe.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key;
  logic             key_vld;
  logic             key_held;

  modport master (output key, key_vld, key_held);
  modport slave  (input  key, key_vld, key_held);

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; 2-cycle latency, idles high.
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] rs
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 4'hF;
      rs   <= 4'hF;
    end else begin
      meta <= row;
      rs   <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce; strobe <= (4+DEBOUNCE)*SCAN_DIV+3 cycles after press.
// No backpressure: key_vld is a one-cycle strobe. KEYPAD_AUTOREPEAT_EN adds repeat strobes while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3,
  parameter int REPEAT   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               row,
  output logic [3:0]               col,
  keypad_scanner_if.master         kif
);

  if (SCAN_DIV < 3) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be 3 or more");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE must be 1 or more");
  end
  if (REPEAT < 1) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT must be 1 or more");
  end

  localparam int            CW         = $clog2(SCAN_DIV);
  localparam int            DW         = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_N      = DW'(DEBOUNCE);

  logic [3:0]       rs;
  state_t           state;
  logic [CW-1:0]    dwell;
  logic [3:0]       pat;
  logic [KEY_W-1:0] code;
  logic [DW-1:0]    match_cnt;
  logic [DW-1:0]    rel_cnt;
  logic [KEY_W-1:0] key_r;
  logic             key_vld_r;
  logic             key_held_r;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int            RW    = $clog2(REPEAT + 1);
  localparam logic [RW-1:0] REP_N = RW'(REPEAT);
  logic [RW-1:0]            rep_cnt;
`endif

  logic             sample;
  logic [2:0]       nlow;
  logic [KEY_W-1:0] code_now;
  logic [3:0]       col_next;

  keypad_row_sync u_row_sync (
    .clk (clk),
    .rst (rst),
    .row (row),
    .rs  (rs)
  );

  assign sample   = (dwell == DWELL_LAST);
  assign nlow     = low_count(rs);
  assign code_now = {low_index(rs), low_index(col)};
  assign col_next = {col[2:0], col[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      dwell      <= '0;
      col        <= COL_RESET;
      pat        <= 4'hF;
      code       <= '0;
      match_cnt  <= '0;
      rel_cnt    <= '0;
      key_r      <= '0;
      key_vld_r  <= 1'b0;
      key_held_r <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      key_vld_r <= 1'b0;
      dwell     <= sample ? '0 : dwell + CW'(1);

      if (sample) begin
        case (state)
          SCAN: begin
            // Ghosted (multi-row) samples are treated like an idle column.
            if (nlow == 3'd1) begin
              pat       <= rs;
              code      <= code_now;
              match_cnt <= DW'(1);
              if (DEBOUNCE == 1) begin
                key_r      <= code_now;
                key_vld_r  <= 1'b1;
                key_held_r <= 1'b1;
                rel_cnt    <= '0;
                state      <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt    <= '0;
`endif
              end else begin
                state <= DEB;
              end
            end else begin
              col <= col_next;
            end
          end

          DEB: begin
            if (rs == pat) begin
              match_cnt <= match_cnt + DW'(1);
              if (match_cnt + DW'(1) == DEB_N) begin
                key_r      <= code;
                key_vld_r  <= 1'b1;
                key_held_r <= 1'b1;
                rel_cnt    <= '0;
                state      <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt    <= '0;
`endif
              end
            end else begin
              match_cnt <= '0;
              col       <= col_next;
              state     <= SCAN;
            end
          end

          HELD: begin
            // Release needs DEBOUNCE consecutive idle samples; any activity restarts the count.
            if (rs == 4'hF) begin
              if (rel_cnt + DW'(1) == DEB_N) begin
                rel_cnt    <= '0;
                key_held_r <= 1'b0;
                col        <= col_next;
                state      <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + DW'(1);
              end
            end else begin
              rel_cnt <= '0;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rs == pat) begin
              if (rep_cnt + RW'(1) == REP_N) begin
                rep_cnt   <= '0;
                key_vld_r <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
            end else begin
              rep_cnt <= '0;
            end
`endif
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

  assign kif.key      = key_r;
  assign kif.key_vld  = key_vld_r;
  assign kif.key_held = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives row from col; a scoreboard checks each strobe.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] press;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (3),
    .REPEAT   (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .row (row),
    .col (col),
    .kif (kif)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         strobes = 0;
  logic [3:0] exp_q[$];
  int         vld_times[$];
  logic       prev_held = 1'b0;
  logic [3:0] last_code = 4'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_ge(input string nm, input int act, input int lo);
    total++;
    if (act < lo) begin
      bad++;
      $display("FAIL %s: got %0d expected at least %0d", nm, act, lo);
    end
  endtask

  // Scoreboard: first strobe of a press pops the expected code; repeats reuse it.
  always @(negedge clk) begin
    if (kif.key_vld === 1'b1) begin
      strobes++;
      vld_times.push_back(cyc);
      if (!prev_held) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: got key %0d expected no strobe", kif.key);
        end else begin
          last_code = exp_q.pop_front();
          check("strobe_key", int'(kif.key), int'(last_code));
        end
      end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
        check("repeat_key", int'(kif.key), int'(last_code));
`else
        total++;
        bad++;
        $display("FAIL repeat_strobe: got key %0d expected one strobe per press", kif.key);
`endif
      end
    end
    prev_held = (kif.key_held === 1'b1);
  end

  task automatic wait_col(input logic [3:0] c);
    int n;
    n = 0;
    while (col == c && n < 40) begin @(negedge clk); n++; end
    while (col != c && n < 80) begin @(negedge clk); n++; end
    check("wait_col", int'(col), int'(c));
  endtask

  typedef struct {
    logic [15:0] mask;
    int          hold;
    int          rel;
    int          n_exp;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         s0;
    int         chg;
    int         idx;
    logic [3:0] pc;
    logic [3:0] kept;

    vecs[0] = '{16'h0001 << 6,  200, 40, 1, 4'd6};
    vecs[1] = '{16'h0001 << 15, 100, 40, 1, 4'd15};
    vecs[2] = '{16'h0001,       100, 40, 1, 4'd0};
    vecs[3] = '{16'h0101,       100, 40, 0, 4'd0};
    vecs[4] = '{16'h0001 << 12, 100, 40, 1, 4'd12};
    vecs[5] = '{16'h0001 << 3,  100, 40, 1, 4'd3};

    press = '0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_col", int'(col), int'(COL_RESET));
    check("rst_key", int'(kif.key), 0);
    check("rst_vld", int'(kif.key_vld), 0);
    check("rst_held", int'(kif.key_held), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("col_before_first_step", int'(col), 14);
    @(negedge clk);
    check("col_first_step", int'(col), 13);

    kept = 4'd0;
    for (int i = 0; i < 6; i++) begin
      s0 = strobes;
      if (vecs[i].n_exp > 0) exp_q.push_back(vecs[i].code);
      press = vecs[i].mask;
      chg = 0;
      pc  = col;
      for (int c = 0; c < vecs[i].hold; c++) begin
        @(negedge clk);
        if (col != pc) chg++;
        pc = col;
      end
      if (vecs[i].n_exp > 0) begin
        check($sformatf("held_during_%0d", i), int'(kif.key_held), 1);
        kept = vecs[i].code;
      end else begin
        check_ge($sformatf("col_advance_%0d", i), chg, 8);
      end
      press = '0;
      repeat (4) @(negedge clk);
      if (vecs[i].n_exp > 0)
        check($sformatf("held_after_release_%0d", i), int'(kif.key_held), 1);
      repeat (vecs[i].rel - 4) @(negedge clk);
      check($sformatf("released_%0d", i), int'(kif.key_held), 0);
      check($sformatf("key_kept_%0d", i), int'(kif.key), int'(kept));
`ifdef KEYPAD_AUTOREPEAT_EN
      check_ge($sformatf("strobes_%0d", i), strobes - s0, vecs[i].n_exp);
`else
      check($sformatf("strobes_%0d", i), strobes - s0, vecs[i].n_exp);
`endif
    end

    // Bounce: two matching samples of code 6, then release.
    s0 = strobes;
    wait_col(4'b1011);
    press = 16'h0001 << 6;
    repeat (8) @(negedge clk);
    press = '0;
    chg = 0;
    pc  = col;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (col != pc) chg++;
      pc = col;
    end
    check_ge("bounce_col_advance", chg, 8);
    check("bounce_strobes", strobes - s0, 0);
    check("bounce_held", int'(kif.key_held), 0);

    // Reset after two matching samples of code 9, then re-detection.
    s0 = strobes;
    wait_col(4'b1101);
    press = 16'h0001 << 9;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("middeb_col", int'(col), int'(COL_RESET));
    check("middeb_key", int'(kif.key), 0);
    check("middeb_vld", int'(kif.key_vld), 0);
    check("middeb_held", int'(kif.key_held), 0);
    rst = 1'b0;
    @(negedge clk);
    check("middeb_vld_after", int'(kif.key_vld), 0);
    check("middeb_no_strobe", strobes - s0, 0);
    exp_q.push_back(4'd9);
    repeat (100) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_ge("redetect_strobes", strobes - s0, 1);
`else
    check("redetect_strobes", strobes - s0, 1);
`endif
    check("redetect_key", int'(kif.key), 9);
    press = '0;
    repeat (40) @(negedge clk);

`ifdef KEYPAD_AUTOREPEAT_EN
    idx = vld_times.size();
    exp_q.push_back(4'd12);
    press = 16'h0001 << 12;
    repeat (150) @(negedge clk);
    press = '0;
    check_ge("repeat_count", vld_times.size() - idx, 5);
    for (int k = idx + 1; k < vld_times.size(); k++)
      check($sformatf("repeat_gap_%0d", k - idx), vld_times[k] - vld_times[k-1], 20);
    repeat (40) @(negedge clk);
`else
    idx = 0;
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
